// File: rtl/blk_79b7e8.sv
// Descriptor chain walker: fetches 4-word descriptors over the memory port, hands them to the
// DMA engine with valid/ready, writes the completion status back and follows the next pointer.
module blk_79b7e8 #(
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           first_desc,
  output logic                  m_chipselect,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [3:0]            m_byteenable,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [31:0]           desc_buf_addr,
  output logic [15:0]           desc_length,
  output logic                  desc_eop,
  input  logic                  dma_done,
  input  logic [15:0]           dma_status,
  output logic                  busy,
  output logic                  chain_done,
  output logic                  chain_error
);

  // desc_valid/desc_ready: a descriptor transfers on any clock edge where both are high; while
  // desc_valid is high and desc_ready low, desc_buf_addr/desc_length/desc_eop hold their values.

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_WRITEBACK,
    S_NEXT
  } state_e;

  localparam logic [31:0] MAX_WORD = 32'((2 ** ADDR_WIDTH) - 4);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [1:0]              issue_cnt_q, issue_cnt_d;
  logic [1:0]              cap_cnt_q, cap_cnt_d;
  logic [RD_LATENCY-1:0]   rd_sr_q, rd_sr_d;
  logic [31:0]             w0_q, w0_d;
  logic [31:0]             w1_q, w1_d;
  logic [31:0]             w2_q, w2_d;
  logic                    cs_q, cs_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    enter_fetch;
  logic [ADDR_WIDTH-1:0]   fetch_ptr;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    cs_d        = 1'b0;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    be_d        = 4'hF;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    enter_fetch = 1'b0;
    fetch_ptr   = ptr_q;

    // rd_sr tracks reads the memory has sampled; its top bit marks the cycle data is valid
    rd_sr_d[0] = rd_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_sr_d[i] = rd_sr_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          enter_fetch = 1'b1;
          fetch_ptr   = first_desc[ADDR_WIDTH+1:2];
        end
      end
      S_FETCH: begin
        if (issue_cnt_q != 2'd3) begin
          cs_d        = 1'b1;
          rd_d        = 1'b1;
          addr_d      = ptr_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 2'd1;
        end
        if (rd_sr_q[RD_LATENCY-1]) begin
          case (cap_cnt_q)
            2'd0:    w0_d = m_readdata;
            2'd1:    w1_d = m_readdata;
            default: w2_d = m_readdata;
          endcase
          cap_cnt_d = cap_cnt_q + 2'd1;
          if (cap_cnt_q == 2'd2) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!w2_q[31] || abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (desc_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (dma_done) begin
          wdata_d = {1'b0, w2_q[30], 14'b0, dma_status};
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ptr_q + ADDR_WIDTH'(2'd3);
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if ((w1_q == 32'd0) || abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if ((w1_q[1:0] != 2'b00) || ({2'b00, w1_q[31:2]} > MAX_WORD)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          enter_fetch = 1'b1;
          fetch_ptr   = w1_q[ADDR_WIDTH+1:2];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // first read goes out on the same edge that enters FETCH
    if (enter_fetch) begin
      state_d     = S_FETCH;
      ptr_d       = fetch_ptr;
      cs_d        = 1'b1;
      rd_d        = 1'b1;
      addr_d      = fetch_ptr;
      issue_cnt_d = 2'd1;
      cap_cnt_d   = 2'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      rd_sr_q     <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      be_q        <= 4'h0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_sr_q     <= rd_sr_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign m_chipselect  = cs_q;
  assign m_address     = addr_q;
  assign m_read        = rd_q;
  assign m_write       = wr_q;
  assign m_byteenable  = be_q;
  assign m_writedata   = wdata_q;
  assign desc_valid    = valid_q;
  assign desc_buf_addr = w0_q;
  assign desc_length   = w2_q[15:0];
  assign desc_eop      = w2_q[30];
  assign busy          = busy_q;
  assign chain_done    = done_q;
  assign chain_error   = err_q;

  logic unused_bits;
  assign unused_bits = ^{first_desc[31:ADDR_WIDTH+2], first_desc[1:0], w2_q[29:16]};

endmodule

// File: tb/tb_blk_79b7e8.sv
// Bench for blk_79b7e8: memory and DMA responder models around the walker, with a chain-walking
// reference model that predicts presented descriptors, writebacks, read counts and chain outcome.
module tb_blk_79b7e8;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [31:0]   first_desc;
  logic          m_chipselect, m_read, m_write;
  logic [AW-1:0] m_address;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata, m_readdata;
  logic          desc_valid, desc_ready, desc_eop;
  logic [31:0]   desc_buf_addr;
  logic [15:0]   desc_length;
  logic          dma_done;
  logic [15:0]   dma_status;
  logic          busy, chain_done, chain_error;

  blk_79b7e8 #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .first_desc(first_desc),
    .m_chipselect(m_chipselect), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_buf_addr(desc_buf_addr),
    .desc_length(desc_length), .desc_eop(desc_eop), .dma_done(dma_done),
    .dma_status(dma_status), .busy(busy), .chain_done(chain_done), .chain_error(chain_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model (read latency 1) ----------------
  logic [31:0] mem [DEPTH];
  logic [31:0] shadow [DEPTH];
  int n_reads = 0;
  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      m_readdata <= mem[m_address];
      n_reads = n_reads + 1;
    end else begin
      m_readdata <= $urandom();
    end
    if (m_chipselect && m_write) mem[m_address] <= m_writedata;
  end

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_desc_q[$];
  logic [15:0] status_q[$];
  logic [42:0] exp_wb_q[$];
  logic [1:0]  exp_end = 2'b10;
  int          exp_reads = 0;
  int          ends_seen = 0;
  int          ends_before = 0;
  int          start_cyc = 0;
  int          first_valid_cyc = -1;
  logic        prev_valid = 1'b0;

  // responder configuration
  int          hs_idx = 0, abort_idx_cfg = -1, stall_idx_cfg = -1, stall_len_cfg = 0;
  int          stall_left = 0, pend_wait = 0;
  logic        pend = 1'b0, abort_arm = 1'b0, spur_req = 1'b0, spur_cfg = 1'b0;
  logic        ready_block = 1'b0, ready_random = 1'b0, r;
  logic [15:0] pend_status = '0;

  // Reference model: walk the chain over a copy of memory using the descriptor rules directly.
  task automatic build_expect(input logic [31:0] first, input int abort_idx, input int fixed_status);
    int p, idx;
    logic [31:0] w0, w1, w2, wb;
    logic [15:0] st;
    exp_desc_q.delete(); status_q.delete(); exp_wb_q.delete();
    exp_reads = 0;
    exp_end = 2'b10;
    for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
    p = int'(first / 4) % DEPTH;
    idx = 0;
    for (int guard = 0; guard < 32; guard++) begin
      w0 = shadow[p]; w1 = shadow[(p + 1) % DEPTH]; w2 = shadow[(p + 2) % DEPTH];
      exp_reads += 3;
      if (w2[31] == 1'b0) break;
      st = (fixed_status >= 0) ? 16'(fixed_status) : 16'($urandom_range(0, int'(w2[15:0])));
      exp_desc_q.push_back({w2[30], w2[15:0], w0});
      status_q.push_back(st);
      wb = {1'b0, w2[30], 14'b0, st};
      exp_wb_q.push_back({11'((p + 3) % DEPTH), wb});
      shadow[(p + 3) % DEPTH] = wb;
      if (idx == abort_idx || w1 == 32'd0) break;
      if ((w1 % 4 != 0) || (w1 / 4 > 32'(DEPTH - 4))) begin
        exp_end = 2'b01;
        break;
      end
      p = int'(w1 / 4);
      idx++;
    end
  endtask

  task automatic put_desc(input int wa, input logic [31:0] buf_a, input logic [31:0] nxt,
                          input logic own, input logic eop, input logic [15:0] len);
    logic [31:0] rs;
    rs = $urandom();
    mem[wa % DEPTH]       = buf_a;
    mem[(wa + 1) % DEPTH] = nxt;
    mem[(wa + 2) % DEPTH] = {own, eop, rs[13:0], len};
    mem[(wa + 3) % DEPTH] = {16'hA5A5, rs[31:16]};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (m_read || m_write) chk("rd_wr_excl", {m_read & m_write, m_chipselect}, 2'b01);
      if (m_write) begin
        if (exp_wb_q.size() == 0) chk("unexpected_wb", 1, 0);
        else chk("wb", {m_byteenable, m_address, m_writedata}, {4'hF, exp_wb_q.pop_front()});
      end
      if (chain_done || chain_error) begin
        ends_seen++;
        chk("chain_end_kind", {chain_done, chain_error}, exp_end);
      end
      if (desc_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_valid = desc_valid;
    end
  end

  // ---------------- DMA responder ----------------
  initial begin
    desc_ready = 1'b0; dma_done = 1'b0; dma_status = '0; abort = 1'b0;
    forever begin
      @(negedge clk);
      dma_done = 1'b0;
      if (reset) begin
        pend = 1'b0; stall_left = 0; abort_arm = 1'b0; abort = 1'b0; desc_ready = 1'b0;
      end else begin
        if (chain_done || chain_error) abort = 1'b0;
        if (abort_arm) begin abort = 1'b1; abort_arm = 1'b0; end
        if (pend) begin
          if (pend_wait == 0) begin dma_done = 1'b1; dma_status = pend_status; pend = 1'b0; end
          else pend_wait--;
        end else if (spur_req && desc_valid && stall_left > 0) begin
          dma_done = 1'b1; dma_status = 16'hBEEF; spur_req = 1'b0;
        end
        if (desc_valid) begin
          if (exp_desc_q.size() == 0) chk("unexpected_desc", 1, 0);
          else chk("desc_fields", {desc_eop, desc_length, desc_buf_addr}, exp_desc_q[0]);
        end
        if (ready_block) r = 1'b0;
        else if (desc_valid && stall_left > 0) begin r = 1'b0; stall_left--; end
        else if (ready_random) r = 1'($urandom_range(0, 1));
        else r = 1'b1;
        desc_ready = r;
        if (desc_valid && r) begin
          if (exp_desc_q.size() != 0) void'(exp_desc_q.pop_front());
          if (status_q.size() != 0) pend_status = status_q.pop_front();
          else pend_status = '0;
          pend = 1'b1;
          pend_wait = $urandom_range(0, 4);
          if (hs_idx == abort_idx_cfg) abort_arm = 1'b1;
          if (hs_idx + 1 == stall_idx_cfg) begin stall_left = stall_len_cfg; spur_req = spur_cfg; end
          hs_idx++;
        end
      end
    end
  end

  task automatic begin_chain(input logic [31:0] first, input int abort_idx, input int fixed_status,
                             input logic rnd_ready, input int stall_idx, input int stall_len,
                             input logic spur);
    build_expect(first, abort_idx, fixed_status);
    hs_idx = 0;
    abort_idx_cfg = abort_idx;
    ready_random = rnd_ready;
    stall_idx_cfg = stall_idx;
    stall_len_cfg = stall_len;
    spur_cfg = spur;
    stall_left = (stall_idx == 0) ? stall_len : 0;
    spur_req = (stall_idx == 0) ? spur : 1'b0;
    n_reads = 0;
    ends_before = ends_seen;
    first_valid_cyc = -1;
    @(negedge clk);
    first_desc = first;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    first_desc = $urandom();
  endtask

  task automatic finish_chain(input int timeout);
    for (int i = 0; i < timeout; i++) begin
      @(negedge clk);
      if (ends_seen != ends_before) break;
    end
    chk("chain_ended", ends_seen - ends_before, 1);
    repeat (4) @(negedge clk);
    chk("single_end", ends_seen - ends_before, 1);
    chk("busy_idle", busy, 0);
    chk("desc_left", exp_desc_q.size(), 0);
    chk("wb_left", exp_wb_q.size(), 0);
    chk("read_count", n_reads, exp_reads);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {m_chipselect, m_address, m_read, m_write, m_byteenable, desc_valid,
                        busy, chain_done, chain_error}, 0);
    chk({tag, "_wdata"}, m_writedata, 0);
    chk({tag, "_desc"}, {desc_buf_addr, desc_length, desc_eop}, 0);
  endtask

  initial begin
    logic [31:0] saved2, saved3, decoy;
    reset = 1'b1; start = 1'b0; first_desc = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // single descriptor at 0x100, status 64, plain then with eop
    put_desc(32'h40, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 16'd64);
    begin_chain(32'h100, -1, 64, 1'b0, -1, 0, 1'b0);
    finish_chain(200);
    chk("s1_latency", first_valid_cyc - start_cyc - 1, 5);
    chk("s1_wb_mem", mem[32'h43], 32'h0000_0040);
    put_desc(32'h40, 32'hCAFE_0000, 32'h0, 1'b1, 1'b1, 16'd64);
    begin_chain(32'h100, -1, 64, 1'b0, -1, 0, 1'b0);
    finish_chain(200);
    chk("s1_eop_wb_mem", mem[32'h43], 32'h4000_0040);

    // 3-chain with a 7-cycle stall and a stray dma_done on the 2nd, plus a start while busy
    put_desc(32'h00, $urandom(), 32'h40, 1'b1, 1'b0, 16'($urandom_range(1, 2000)));
    put_desc(32'h10, $urandom(), 32'h80, 1'b1, 1'b1, 16'($urandom_range(1, 2000)));
    put_desc(32'h20, $urandom(), 32'h0, 1'b1, 1'b1, 16'($urandom_range(1, 2000)));
    put_desc(32'hC0, $urandom(), 32'h0, 1'b1, 1'b0, 16'd8);
    decoy = mem[32'hC3];
    begin_chain(32'h0, -1, -1, 1'b0, 1, 7, 1'b1);
    repeat (10) @(negedge clk);
    first_desc = 32'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_chain(400);
    chk("busy_start_ignored", mem[32'hC3], decoy);

    // second descriptor not owned: stops without touching it
    put_desc(32'h80, $urandom(), 32'h240, 1'b1, 1'b0, 16'd100);
    put_desc(32'h90, $urandom(), 32'h0, 1'b0, 1'b0, 16'd50);
    saved2 = mem[32'h92]; saved3 = mem[32'h93];
    begin_chain(32'h200, -1, -1, 1'b1, -1, 0, 1'b0);
    finish_chain(300);
    chk("own0_word2", mem[32'h92], saved2);
    chk("own0_word3", mem[32'h93], saved3);

    // bad next pointers, then the highest legal one, then an address wrap
    put_desc(32'h180, $urandom(), 32'h102, 1'b1, 1'b0, 16'd20);
    begin_chain(32'h600, -1, -1, 1'b0, -1, 0, 1'b0);
    finish_chain(300);
    put_desc(32'h180, $urandom(), 32'h1FF4, 1'b1, 1'b1, 16'd20);
    begin_chain(32'h600, -1, -1, 1'b0, -1, 0, 1'b0);
    finish_chain(300);
    put_desc(32'h190, $urandom(), 32'h1FF0, 1'b1, 1'b0, 16'd30);
    put_desc(32'h7FC, $urandom(), 32'h0, 1'b1, 1'b1, 16'd31);
    begin_chain(32'h640, -1, -1, 1'b1, -1, 0, 1'b0);
    finish_chain(300);
    put_desc(32'h7FE, $urandom(), 32'h0, 1'b1, 1'b0, 16'd77);
    begin_chain(32'h0000_3FF8, -1, -1, 1'b0, -1, 0, 1'b0);
    finish_chain(300);

    // abort during WAIT_DONE of the first descriptor
    put_desc(32'h1C0, $urandom(), 32'h740, 1'b1, 1'b0, 16'd40);
    put_desc(32'h1D0, $urandom(), 32'h0, 1'b1, 1'b0, 16'd41);
    begin_chain(32'h700, 0, -1, 1'b0, -1, 0, 1'b0);
    finish_chain(300);

    // random chains with random ready
    for (int t = 0; t < 5; t++) begin
      int n, term;
      int slots[6];
      bit dup;
      logic [31:0] nx;
      n = $urandom_range(1, 4);
      for (int k = 0; k <= n; k++) begin
        do begin
          slots[k] = 4 * $urandom_range(64, 500);
          dup = 1'b0;
          for (int j = 0; j < k; j++) if (slots[j] == slots[k]) dup = 1'b1;
        end while (dup);
      end
      term = $urandom_range(0, 1);
      for (int k = 0; k < n; k++) begin
        nx = (k == n - 1 && term == 0) ? 32'h0 : 32'(slots[k+1] * 4);
        put_desc(slots[k], $urandom(), nx, 1'b1, 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 1500)));
      end
      put_desc(slots[n], $urandom(), 32'h0, 1'b0, 1'b0, 16'd0);
      begin_chain(32'(slots[0] * 4), -1, -1, 1'b1, -1, 0, 1'b0);
      finish_chain(600);
    end

    // reset while presenting a descriptor, then a fresh single-descriptor run
    put_desc(32'h40, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 16'd64);
    ready_block = 1'b1;
    begin_chain(32'h100, -1, 64, 1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (desc_valid) break;
      @(negedge clk);
    end
    chk("reached_issue", desc_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    ready_block = 1'b0;
    exp_desc_q.delete(); status_q.delete(); exp_wb_q.delete();
    repeat (2) @(negedge clk);
    begin_chain(32'h100, -1, 64, 1'b0, -1, 0, 1'b0);
    finish_chain(200);
    chk("post_reset_latency", first_valid_cyc - start_cyc - 1, 5);
    chk("post_reset_wb_mem", mem[32'h43], 32'h0000_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
